pipe_stage_skid: RTL and testbench

Parametrised pipeline-stage register, successor to the fixed inter-stage latches (MEM/WB style) in the microprocessor pipeline. Carries NUM_WORDS data words plus a control bundle between two stages. Adds a valid/ready handshake, an optional 2-entry skid buffer for full throughput with registered backpressure, synchronous flush with control-bubble insertion, and asynchronous reset. One instance is placed per pipeline boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_skid.sv | 122 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline boundary register with a valid/ready handshake and an optional 2-entry skid buffer.
// A flush kills all held bundles and turns out_ctrl into a NOP bubble.
module pipe_stage_skid #(
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 2,
    parameter int CTRL_W    = 2,
    parameter int SKID      = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_WORDS*DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0]           in_ctrl,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_WORDS*DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0]           out_ctrl,
    output logic [1:0]                  occupancy
);
    localparam int W = NUM_WORDS * DATA_W;

    logic              main_valid, main_valid_n;
    logic [W-1:0]      main_data, main_data_n;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_n;
    logic              skid_valid, skid_valid_n;
    logic [W-1:0]      skid_data, skid_data_n;
    logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_n;
    logic              ready_q;
    logic              accept;
    logic              main_load;

    // main_ctrl is cleared whenever main goes invalid, so out_ctrl is a NOP without extra gating
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;

    // Next-state selection for main and skid entries; flush overrides every transfer
    always_comb begin
        accept       = in_valid && in_ready;
        main_load    = !main_valid || out_ready;
        main_valid_n = main_valid;
        main_data_n  = main_data;
        main_ctrl_n  = main_ctrl;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;
        skid_ctrl_n  = skid_ctrl;
        if (flush) begin
            main_valid_n = 1'b0;
            main_ctrl_n  = {CTRL_W{1'b0}};
            skid_valid_n = 1'b0;
        end else if (main_load) begin
            if (skid_valid) begin
                main_valid_n = 1'b1;
                main_data_n  = skid_data;
                main_ctrl_n  = skid_ctrl;
                skid_valid_n = accept;
                if (accept) begin
                    skid_data_n = in_data;
                    skid_ctrl_n = in_ctrl;
                end else begin
                    skid_data_n = skid_data;
                end
            end else if (accept) begin
                main_valid_n = 1'b1;
                main_data_n  = in_data;
                main_ctrl_n  = in_ctrl;
            end else begin
                main_valid_n = 1'b0;
                main_ctrl_n  = {CTRL_W{1'b0}};
            end
        end else if (accept) begin
            skid_valid_n = 1'b1;
            skid_data_n  = in_data;
            skid_ctrl_n  = in_ctrl;
        end else begin
            skid_valid_n = skid_valid;
        end
    end

    // Main entry, registered ready and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_data  <= {W{1'b0}};
            main_ctrl  <= {CTRL_W{1'b0}};
            ready_q    <= 1'b0;
            occupancy  <= 2'd0;
        end else begin
            main_valid <= main_valid_n;
            main_data  <= main_data_n;
            main_ctrl  <= main_ctrl_n;
            ready_q    <= !skid_valid_n;
            occupancy  <= {1'b0, main_valid_n} + {1'b0, skid_valid_n};
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            // Overflow entry; ready_q alone drives in_ready so out_ready never reaches it
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    skid_valid <= 1'b0;
                    skid_data  <= {W{1'b0}};
                    skid_ctrl  <= {CTRL_W{1'b0}};
                end else begin
                    skid_valid <= skid_valid_n;
                    skid_data  <= skid_data_n;
                    skid_ctrl  <= skid_ctrl_n;
                end
            end
            assign in_ready = ready_q;
        end else begin : g_noskid
            assign skid_valid = 1'b0;
            assign skid_data  = {W{1'b0}};
            assign skid_ctrl  = {CTRL_W{1'b0}};
            // ready_q stays low until the first edge after reset
            assign in_ready   = ready_q && (out_ready || !main_valid);
        end
    endgenerate
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: one SKID=1 instance (u_skid) and one SKID=0 instance (u_flat).
module tb_pipe_stage_skid;
    logic        clk = 1'b0;
    logic        rst;
    logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
    logic [63:0] a_in_data, a_out_data;
    logic [1:0]  a_in_ctrl, a_out_ctrl, a_occ;
    logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
    logic [63:0] b_in_data, b_out_data;
    logic [1:0]  b_in_ctrl, b_out_ctrl, b_occ;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(32), .NUM_WORDS(2), .CTRL_W(2), .SKID(1)) u_skid (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_ctrl(a_in_ctrl), .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_ctrl(a_out_ctrl), .occupancy(a_occ));

    pipe_stage_skid #(.DATA_W(32), .NUM_WORDS(2), .CTRL_W(2), .SKID(0)) u_flat (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_ctrl(b_in_ctrl), .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_ctrl(b_out_ctrl), .occupancy(b_occ));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // upper word carries v+0x100 so word placement is checked too
    function automatic logic [63:0] pack(input logic [31:0] v);
        return {v + 32'h100, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int got_cnt;
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = 64'd0; a_in_ctrl = 2'b00; a_flush = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = 64'd0; b_in_ctrl = 2'b00; b_flush = 1'b0; b_out_ready = 1'b0;

        // 1: reset values, in_ready rises one edge after release
        tick(); tick(); tick();
        chk("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
        chk("rst_out_ctrl", {62'd0, a_out_ctrl}, 64'd0);
        chk("rst_out_data", a_out_data, 64'd0);
        chk("rst_occ", {62'd0, a_occ}, 64'd0);
        chk("rst_in_ready", {63'd0, a_in_ready}, 64'd0);
        chk("rst_in_ready_flat", {63'd0, b_in_ready}, 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready_low", {63'd0, a_in_ready}, 64'd0);
        tick();
        chk("rel_in_ready_high", {63'd0, a_in_ready}, 64'd1);
        chk("rel_in_ready_flat", {63'd0, b_in_ready}, 64'd1);

        // 2: streaming 1..8, one-cycle latency, occupancy 1
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in_ctrl = 2'b01; a_in_data = pack(32'd1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("strm_valid", {63'd0, a_out_valid}, 64'd1);
            chk("strm_data", a_out_data, pack(i));
            chk("strm_ctrl", {62'd0, a_out_ctrl}, 64'd1);
            chk("strm_occ", {62'd0, a_occ}, 64'd1);
            if (i < 8) a_in_data = pack(i + 1);
            else a_in_valid = 1'b0;
        end
        tick();
        chk("strm_empty_valid", {63'd0, a_out_valid}, 64'd0);
        chk("strm_empty_ctrl", {62'd0, a_out_ctrl}, 64'd0);
        chk("strm_empty_occ", {62'd0, a_occ}, 64'd0);

        // 3: fill both entries under backpressure, then drain in order
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_ctrl = 2'b10; a_in_data = pack(32'h10);
        tick();
        chk("bp_a_occ", {62'd0, a_occ}, 64'd1);
        chk("bp_a_ready", {63'd0, a_in_ready}, 64'd1);
        a_in_data = pack(32'h20);
        tick();
        chk("bp_b_occ", {62'd0, a_occ}, 64'd2);
        chk("bp_b_ready", {63'd0, a_in_ready}, 64'd0);
        chk("bp_b_data", a_out_data, pack(32'h10));
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        tick();
        chk("drain_b_data", a_out_data, pack(32'h20));
        chk("drain_b_occ", {62'd0, a_occ}, 64'd1);
        chk("drain_b_ready", {63'd0, a_in_ready}, 64'd1);
        tick();
        chk("drain_end_valid", {63'd0, a_out_valid}, 64'd0);

        // 4: flush with two held bundles and a pending input
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_ctrl = 2'b11; a_in_data = pack(32'h11);
        tick();
        a_in_data = pack(32'h21);
        tick();
        chk("fl_pre_occ", {62'd0, a_occ}, 64'd2);
        a_flush = 1'b1; a_in_data = pack(32'h30);
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        chk("fl_valid", {63'd0, a_out_valid}, 64'd0);
        chk("fl_ctrl", {62'd0, a_out_ctrl}, 64'd0);
        chk("fl_occ", {62'd0, a_occ}, 64'd0);
        chk("fl_ready", {63'd0, a_in_ready}, 64'd1);
        chk("fl_data_kept", a_out_data, pack(32'h11));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_no_30", {63'd0, a_out_valid}, 64'd0);
        end

        // 5: SKID=0, out_ready toggles every cycle while streaming 0xA..0xF
        sent = 0; got_cnt = 0;
        b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_ctrl = 2'b01; b_in_data = pack(32'hA);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (b_out_valid) chk("flat_ready_follow", {63'd0, b_in_ready}, {63'd0, b_out_ready});
            if (b_out_valid && b_out_ready) begin
                chk("flat_data", b_out_data, pack(32'hA + got_cnt));
                got_cnt++;
            end
            if (b_in_valid && b_in_ready) sent++;
            chk("flat_occ_le1", {63'd0, b_occ > 2'd1}, 64'd0);
            tick();
            b_out_ready = ~b_out_ready;
            b_in_valid = (sent < 6);
            b_in_data = pack(32'hA + sent);
            if (got_cnt == 6) break;
        end
        chk("flat_all_delivered", got_cnt, 64'd6);
        b_in_valid = 1'b0; b_out_ready = 1'b0;

        // 6: asynchronous reset with two held bundles, then a fresh bundle
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_ctrl = 2'b01; a_in_data = pack(32'h41);
        tick();
        a_in_data = pack(32'h42);
        tick();
        a_in_valid = 1'b0;
        chk("ar_pre_occ", {62'd0, a_occ}, 64'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", {63'd0, a_out_valid}, 64'd0);
        chk("ar_occ", {62'd0, a_occ}, 64'd0);
        chk("ar_ctrl", {62'd0, a_out_ctrl}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("ar_ready", {63'd0, a_in_ready}, 64'd1);
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in_ctrl = 2'b10; a_in_data = pack(32'h55);
        tick();
        a_in_valid = 1'b0;
        chk("ar_55_valid", {63'd0, a_out_valid}, 64'd1);
        chk("ar_55_data", a_out_data, pack(32'h55));
        chk("ar_55_ctrl", {62'd0, a_out_ctrl}, 64'd2);
        tick();
        chk("ar_55_gone", {63'd0, a_out_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
